fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/adder.sv | 10 +
 rtl/fetch_queue.sv | 49 ++++
 rtl/fetch_ctrl.sv | 108 ++++++++++
 tb/tb_fetch_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and sizing for the instruction fetch controller.
package fetch_ctrl_pkg;
    localparam int FQ_DEPTH    = 2;
    localparam int INSTR_W     = 32;
    localparam int ADDR_W      = 64;
    localparam int INSTR_BYTES = 4;
    localparam int CNT_W       = $clog2(FQ_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/adder.sv
// Generic modulo-2^W adder.
module adder #(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);
    assign y = a + b;
endmodule

// File: rtl/fetch_queue.sv
// Small in-order FIFO of fetched {pc, instr}; head is always slot 0.
module fetch_queue
    import fetch_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fq_entry_t        wdata,
    output fq_entry_t        head,
    output logic             valid,
    output logic [CNT_W-1:0] count_nxt
);
    fq_entry_t        slot     [FQ_DEPTH];
    fq_entry_t        slot_nxt [FQ_DEPTH];
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_pop;
    logic             do_push;

    assign head  = slot[0];
    assign valid = (count != '0);

    // Pop shifts toward slot 0, then a push lands in the first free slot.
    always_comb begin
        slot_nxt = slot;
        cnt_pop  = count;
        if (pop && valid) begin
            for (int i = 0; i < FQ_DEPTH - 1; i++) slot_nxt[i] = slot[i+1];
            cnt_pop = count - CNT_W'(1);
        end
        do_push = push && (cnt_pop < CNT_W'(FQ_DEPTH));
        if (do_push) begin
            for (int i = 0; i < FQ_DEPTH; i++)
                if (int'(cnt_pop) == i) slot_nxt[i] = wdata;
        end
        count_nxt = flush ? '0 : cnt_pop + CNT_W'(do_push);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FQ_DEPTH; i++) slot[i] <= '0;
            count <= '0;
        end else begin
            count <= count_nxt;
            if (!flush) slot <= slot_nxt;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: issues word-aligned imem requests, buffers returns, handles redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               PCSrc_F,
    input  logic [ADDR_W-1:0]  PCBranch_F,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall_D,
    output logic               instr_valid_D,
    output logic [INSTR_W-1:0] instr_D,
    output logic [ADDR_W-1:0]  pc_D
);
    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt, addr_nxt, addr_inc, redirect_pc;
    logic              req_nxt, accept, pop, push, issue_ok;
    logic [CNT_W-1:0]  count_nxt;
    fq_entry_t         head;

    assign accept      = imem_req && imem_ready;
    assign pop         = instr_valid_D && !stall_D;
    assign push        = accept && !PCSrc_F && (state == WAIT);
    assign issue_ok    = count_nxt < CNT_W'(FQ_DEPTH);
    assign redirect_pc = {PCBranch_F[ADDR_W-1:2], 2'b00};

    adder #(.W(ADDR_W)) u_inc (
        .a (imem_addr),
        .b (ADDR_W'(INSTR_BYTES)),
        .y (addr_inc)
    );

    fetch_queue u_fq (
        .clk       (clk),
        .rst       (reset),
        .push      (push),
        .pop       (pop),
        .flush     (PCSrc_F),
        .wdata     ('{pc: imem_addr, instr: imem_rdata}),
        .head      (head),
        .valid     (instr_valid_D),
        .count_nxt (count_nxt)
    );

    assign instr_D = head.instr;
    assign pc_D    = head.pc;

    // A live request is never altered before accept; a redirect only retargets pc.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        req_nxt   = imem_req;
        addr_nxt  = imem_addr;
        if (PCSrc_F) pc_nxt = redirect_pc;
        case (state)
            IDLE: if (!PCSrc_F && issue_ok) begin
                state_nxt = WAIT;
                req_nxt   = 1'b1;
                addr_nxt  = pc;
            end
            WAIT: begin
                if (PCSrc_F) begin
                    if (accept) begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (accept) begin
                    pc_nxt = addr_inc;
                    if (issue_ok) begin
                        addr_nxt = addr_inc;
                    end else begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end
                end
            end
            DROP: if (accept) begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            imem_req  <= req_nxt;
            imem_addr <= addr_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed and random checks of fetch_ctrl against a queue-based transaction model.
module tb_fetch_ctrl;
    localparam logic [63:0] RPC = 64'h100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCSrc_F = 1'b0;
    logic [63:0] PCBranch_F = '0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall_D = 1'b0;
    logic        instr_valid_D;
    logic [31:0] instr_D;
    logic [63:0] pc_D;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic        m_req, m_discard;
    logic [63:0] m_addr, m_pc;

    fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk           (clk),
        .reset         (reset),
        .PCSrc_F       (PCSrc_F),
        .PCBranch_F    (PCBranch_F),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall_D       (stall_D),
        .instr_valid_D (instr_valid_D),
        .instr_D       (instr_D),
        .pc_D          (pc_D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        m_req = 1'b0;
        m_discard = 1'b0;
        m_addr = RPC;
        m_pc = RPC;
    endfunction

    // One cycle of transactions: redirect flushes, accepts deliver or discard, free space issues.
    function automatic void model_update(input logic src, input logic [63:0] tgt,
                                         input logic rdy, input logic stl, input logic [31:0] rd);
        logic acc, keep, was_idle;
        acc = m_req && rdy;
        keep = !m_discard;
        was_idle = !m_req;
        if (src) begin
            q.delete();
            m_pc = {tgt[63:2], 2'b00};
            if (acc) begin
                m_req = 1'b0;
                m_discard = 1'b0;
            end else if (m_req) begin
                m_discard = 1'b1;
            end
        end else begin
            if (q.size() != 0 && !stl) void'(q.pop_front());
            if (acc) begin
                m_req = 1'b0;
                m_discard = 1'b0;
                if (keep) begin
                    q.push_back('{pc: m_addr, instr: rd});
                    m_pc = m_addr + 64'd4;
                end
            end
            if ((was_idle || (acc && keep)) && q.size() < 2) begin
                m_req = 1'b1;
                m_addr = m_pc;
            end
        end
    endfunction

    // Called at a falling edge; checks outputs mid-cycle, then advances one cycle.
    task automatic step(input logic src, input logic [63:0] tgt, input logic rdy, input logic stl);
        PCSrc_F = src;
        PCBranch_F = tgt;
        imem_ready = rdy;
        stall_D = stl;
        imem_rdata = $urandom;
        #1;
        chk("req", {63'd0, imem_req}, {63'd0, m_req});
        chk("addr", imem_addr, m_addr);
        chk("valid", {63'd0, instr_valid_D}, {63'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("instr_D", {32'd0, instr_D}, {32'd0, q[0].instr});
            chk("pc_D", pc_D, q[0].pc);
        end
        model_update(src, tgt, rdy, stl, imem_rdata);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        PCSrc_F = 1'b0;
        PCBranch_F = '0;
        imem_ready = 1'b0;
        stall_D = 1'b0;
        #1;
        chk("rst_req", {63'd0, imem_req}, 64'd0);
        chk("rst_addr", imem_addr, RPC);
        chk("rst_valid", {63'd0, instr_valid_D}, 64'd0);
        chk("rst_instr", {32'd0, instr_D}, 64'd0);
        chk("rst_pc_D", pc_D, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic        src, rdy, stl;
        logic [63:0] tgt;
        model_reset();
        @(negedge clk);
        do_reset();

        // back-to-back fetch from RESET_PC
        step(0, 0, 1, 0);
        chk("b2b_a0", imem_addr, 64'h100);
        chk("b2b_v0", {63'd0, instr_valid_D}, 64'd0);
        step(0, 0, 1, 0);
        chk("b2b_a1", imem_addr, 64'h104);
        chk("b2b_v1", {63'd0, instr_valid_D}, 64'd1);
        step(0, 0, 1, 0);
        chk("b2b_a2", imem_addr, 64'h108);

        // decode stall fills the queue and stops requests
        do_reset();
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("stall_req", {63'd0, imem_req}, 64'd0);
        chk("stall_head", pc_D, 64'h100);
        step(0, 0, 1, 1);
        chk("stall_hold", {63'd0, imem_req}, 64'd0);
        step(0, 0, 1, 0);
        chk("stall_resume", imem_addr, 64'h108);

        // memory back-pressure holds the request
        do_reset();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            chk("hold_req", {63'd0, imem_req}, 64'd1);
            chk("hold_addr", imem_addr, 64'h104);
        end

        // redirect while waiting -> discard late response
        do_reset();
        step(0, 0, 0, 0);
        step(1, 64'h203, 0, 0);
        chk("drop_addr", imem_addr, 64'h100);
        step(0, 0, 1, 0);
        chk("drop_q", {63'd0, instr_valid_D}, 64'd0);
        step(0, 0, 1, 0);
        chk("drop_tgt", imem_addr, 64'h200);
        chk("drop_q2", {63'd0, instr_valid_D}, 64'd0);

        // redirect coincident with accept
        do_reset();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(1, 64'h300, 1, 0);
        chk("racc_q", {63'd0, instr_valid_D}, 64'd0);
        chk("racc_req", {63'd0, imem_req}, 64'd0);
        step(0, 0, 1, 0);
        chk("racc_tgt", imem_addr, 64'h300);

        // address wrap at top of space
        do_reset();
        step(1, 64'hFFFF_FFFF_FFFF_FFFE, 0, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        chk("wrap_addr", imem_addr, 64'h0);
        chk("wrap_pc_D", pc_D, 64'hFFFF_FFFF_FFFF_FFFC);

        // asynchronous reset mid-request
        do_reset();
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk("pre_rst_v", {63'd0, instr_valid_D}, 64'd1);
        #2;
        do_reset();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            src = ($urandom % 8) == 0;
            rdy = ($urandom % 3) != 0;
            stl = ($urandom % 4) == 0;
            tgt = {$urandom, $urandom};
            if ($urandom % 4 == 0) tgt = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom % 16);
            step(src, tgt, rdy, stl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
